// File: rtl/iir_pkg.sv
// Constants shared by the IIR filter, its output buffer and the bench.
package iir_pkg;
  localparam int SAMPLE_W  = 12;
  localparam int OBUF_DEPTH = 8;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one write port, asynchronous read port.
module fifo_mem
  import iir_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = OBUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Contents are deliberately left unreset; valid data is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/iir_out_buffer.sv
// Show-ahead FIFO between the IIR filter output and a ready-gated consumer.
module iir_out_buffer
  import iir_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = OBUF_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic [WIDTH-1:0]       DIN,
  input  logic                   VIN,
  input  logic                   CLR,
  input  logic                   READY,
  output logic [WIDTH-1:0]       DOUT,
  output logic                   VOUT,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   OVF,
  output logic [$clog2(DEPTH):0] COUNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          push, pop;

  assign EMPTY = (cnt == '0);
  assign FULL  = (cnt == CNT_FULL);
  assign VOUT  = ~EMPTY;
  assign COUNT = cnt;
  assign OVF   = ovf_q;

  // A pop frees a slot in the same edge, so a full FIFO still accepts when draining.
  assign pop  = VOUT & READY;
  assign push = VIN & (~FULL | pop);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (CLR) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (VIN && !push) ovf_q <= 1'b1;
    end
  end

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (CLK),
    .we    (push & ~CLR),
    .waddr (wptr),
    .wdata (DIN),
    .raddr (rptr),
    .rdata (DOUT)
  );
endmodule

// File: tb/tb_iir_out_buffer.sv
// Directed checks of iir_out_buffer with hand-computed expectations.
module tb_iir_out_buffer;
  import iir_pkg::*;
  localparam int W = SAMPLE_W;
  localparam int D = OBUF_DEPTH;

  logic          CLK = 1'b0;
  logic          RST_n, VIN, CLR, READY;
  logic [W-1:0]  DIN;
  logic [W-1:0]  DOUT;
  logic          VOUT, FULL, EMPTY, OVF;
  logic [$clog2(D):0] COUNT;

  int checks = 0;
  int failures = 0;

  iir_out_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST_n(RST_n), .DIN(DIN), .VIN(VIN), .CLR(CLR), .READY(READY),
    .DOUT(DOUT), .VOUT(VOUT), .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(COUNT), 0);
    chk({tag, "_empty"}, 32'(EMPTY), 1);
    chk({tag, "_full"},  32'(FULL),  0);
    chk({tag, "_vout"},  32'(VOUT),  0);
    chk({tag, "_ovf"},   32'(OVF),   0);
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] d;

  initial begin
    RST_n = 1'b0; VIN = 1'b0; CLR = 1'b0; READY = 1'b0; DIN = '0;
    #2;
    chk_reset_vals("rst");
    tick(); tick();
    RST_n = 1'b1;

    // Basic push then drain, with first-push latency of one edge
    VIN = 1'b1; DIN = 12'h001;
    tick();
    chk("lat_vout", 32'(VOUT), 1);
    chk("lat_dout", 32'(DOUT), 12'h001);
    DIN = 12'h002; tick();
    DIN = 12'h003; tick();
    VIN = 1'b0;
    chk("t1_count", 32'(COUNT), 3);
    chk("t1_head", 32'(DOUT), 12'h001);
    READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_dout", 32'(DOUT), 32'(12'h001 + i));
      tick();
    end
    chk("t1_empty", 32'(EMPTY), 1);
    tick();
    chk("t1_pop_empty", 32'(COUNT), 0);

    // Overflow: ninth push into a full FIFO is dropped
    READY = 1'b0; VIN = 1'b1;
    for (int i = 0; i < 9; i++) begin
      DIN = W'(12'h100 + i);
      tick();
      if (i == 7) begin
        chk("t2_full", 32'(FULL), 1);
        chk("t2_ovf_pre", 32'(OVF), 0);
      end
    end
    VIN = 1'b0;
    chk("t2_ovf", 32'(OVF), 1);
    chk("t2_count", 32'(COUNT), 8);
    READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain", 32'(DOUT), 32'(12'h100 + i));
      tick();
    end
    chk("t2_empty", 32'(EMPTY), 1);
    chk("t2_ovf_sticky", 32'(OVF), 1);
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("t2_clr_ovf", 32'(OVF), 0);

    // Full with simultaneous push and pop across pointer wrap
    READY = 1'b0; VIN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      DIN = W'(12'h200 + i);
      tick();
    end
    READY = 1'b1;
    for (int k = 0; k < 20; k++) begin
      DIN = W'(12'h208 + k);
      chk("t3_stream", 32'(DOUT), 32'(12'h200 + k));
      tick();
      chk("t3_count", 32'(COUNT), 8);
    end
    chk("t3_ovf", 32'(OVF), 0);
    VIN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", 32'(DOUT), 32'(12'h214 + i));
      tick();
    end
    chk("t3_empty", 32'(EMPTY), 1);

    // CLR beats a same-cycle push
    READY = 1'b0; VIN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      DIN = W'(12'h300 + i);
      tick();
    end
    CLR = 1'b1; DIN = 12'h7FF;
    tick();
    CLR = 1'b0; VIN = 1'b0;
    chk("t4_count", 32'(COUNT), 0);
    chk("t4_ovf", 32'(OVF), 0);
    chk("t4_empty", 32'(EMPTY), 1);
    VIN = 1'b1; DIN = 12'h055;
    tick();
    VIN = 1'b0;
    chk("t4_no7ff", 32'(DOUT), 12'h055);
    chk("t4_count1", 32'(COUNT), 1);
    CLR = 1'b1; tick(); CLR = 1'b0;

    // Asynchronous reset with COUNT=4 and OVF=1
    VIN = 1'b1;
    for (int i = 0; i < 9; i++) begin
      DIN = W'(12'h400 + i);
      tick();
    end
    VIN = 1'b0; READY = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    READY = 1'b0;
    chk("t5_pre_count", 32'(COUNT), 4);
    chk("t5_pre_ovf", 32'(OVF), 1);
    #2 RST_n = 1'b0;
    #1;
    chk_reset_vals("t5_async");
    #3 RST_n = 1'b1;
    READY = 1'b1;
    tick();
    chk("t5_post_count", 32'(COUNT), 0);
    READY = 1'b0; VIN = 1'b1; DIN = 12'h0AB;
    tick();
    VIN = 1'b0;
    chk("t5_first_vout", 32'(VOUT), 1);
    chk("t5_first_dout", 32'(DOUT), 12'h0AB);
    CLR = 1'b1; tick(); CLR = 1'b0;

    // Filter-like stream with random READY (at least 50% duty)
    d = 12'h010;
    for (int c = 0; c < 60; c++) begin
      VIN   = (c % 2 == 0);
      READY = (c % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      DIN   = d;
      if (VOUT && READY) begin
        chk("t6_stream", 32'(DOUT), 32'(q[0]));
        void'(q.pop_front());
      end
      if (VIN) begin
        q.push_back(d);
        d = W'(d * 5 + 7);
      end
      tick();
      chk("t6_count", 32'(COUNT), 32'(q.size()));
    end
    VIN = 1'b0;
    chk("t6_ovf", 32'(OVF), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iir_out_buffer.md
IIR_OUT_BUFFER -- requirements
Module: iir_out_buffer

Interface
REQ-001 Parameter WIDTH, default 12, sample width; it SHALL match the filter DOUT width.
REQ-002 Parameter DEPTH, default 8, FIFO entries; it SHALL be a power of two, 2..16.
REQ-003 CLK  input  1  single clock for the block; all state SHALL update on the rising edge.
REQ-004 RST_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 DIN  input  WIDTH  filtered sample from the IIR filter DOUT.
REQ-006 VIN  input  1  sample valid from the IIR filter VOUT; one sample per high cycle.
REQ-007 CLR  input  1  synchronous flush; it SHALL empty the FIFO and clear OVF.
REQ-008 READY  input  1  downstream consumer can accept DOUT this cycle.
REQ-009 DOUT  output  WIDTH  head-of-FIFO sample.
REQ-010 VOUT  output  1  DOUT valid; VOUT SHALL equal not EMPTY.
REQ-011 FULL  output  1  COUNT equals DEPTH.
REQ-012 EMPTY  output  1  COUNT equals 0.
REQ-013 OVF  output  1  sticky flag: at least one sample was dropped.
REQ-014 COUNT  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 A push SHALL occur on a rising edge with VIN=1 and (FULL=0 or pop in the same cycle); DIN is written at the write pointer.
REQ-016 A pop SHALL occur on a rising edge with VOUT=1 and READY=1; the read pointer advances.
REQ-017 Ordering SHALL be strict FIFO; DOUT SHALL present the entry at the read pointer (show-ahead), with no added pipeline stage.
REQ-018 Latency: a sample pushed into an empty FIFO SHALL appear on DOUT with VOUT=1 on the cycle after the push edge.
REQ-019 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH without special handling.
REQ-020 COUNT SHALL change +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-021 Full boundary: VIN=1 with FULL=1 and READY=1 SHALL accept the sample; COUNT stays DEPTH and OVF is unchanged.
REQ-022 Overflow: VIN=1 with FULL=1 and no pop SHALL drop DIN, leave the memory and pointers unchanged, and set OVF.
REQ-023 Empty boundary: READY=1 with EMPTY=1 SHALL have no effect.
REQ-024 VIN=1 with EMPTY=1 SHALL push only; no same-cycle bypass to DOUT.
REQ-025 OVF SHALL remain 1 until CLR or reset.
REQ-026 CLR=1 SHALL take priority over push and pop: pointers, COUNT and OVF go to 0 next edge, and that cycle's VIN sample is discarded.
REQ-027 Memory contents SHALL NOT be reset; DOUT while EMPTY=1 is don't-care and SHALL NOT be checked.

Reset
REQ-028 RST_n=0 SHALL immediately force pointers=0, COUNT=0, EMPTY=1, FULL=0, VOUT=0 and OVF=0, independent of CLK.
REQ-029 Reset asserted mid-operation SHALL discard all stored samples; no push or pop SHALL occur on the first edge after RST_n rises if VIN or READY is 0.
REQ-030 After reset release, the first push edge SHALL behave as a push into an empty FIFO (REQ-018).

Structure
REQ-031 Package iir_pkg SHALL hold the sample width constant (12), the default DEPTH, and the COUNT-width function/constant shared with the filter and bench.
REQ-032 Storage SHALL be a separate sub-module, fifo_mem: DEPTH x WIDTH register array with one write port and one asynchronous read port.
REQ-033 Pointer, count and flag logic SHALL reside in iir_out_buffer; FULL, EMPTY and VOUT SHALL be decoded from COUNT.

Verification
REQ-034 Reset, then push 0x001..0x003 with READY=0 -> COUNT=3, DOUT=0x001; READY=1 for 3 cycles -> DOUT 0x001, 0x002, 0x003, then EMPTY=1.
REQ-035 With READY=0, push 9 samples 0x100..0x108 -> FULL=1 after the 8th push and OVF=1 after the 9th; draining yields 0x100..0x107 only.
REQ-036 Fill to 8, then VIN=1 and READY=1 for 20 cycles with incrementing data -> COUNT stays 8, OVF=0, output order is continuous, and the pointers wrap correctly.
REQ-037 Push 5 samples, then assert CLR with VIN=1 (DIN=0x7FF) -> next cycle COUNT=0, OVF=0, and 0x7FF is never output.
REQ-038 Hold COUNT=4 and OVF=1, then pulse RST_n low mid-cycle -> outputs reach their reset values before the next CLK edge.
REQ-039 Connect the IIR filter output to DIN/VIN with random READY -> the DOUT stream equals the golden filter output file, and OVF=0 when READY duty is at least 50%.
